// File: rtl/atom_fetch_unit.sv
// Decoupled instruction fetch stage: credit-limited request issue on a req/gnt/rvalid bus,
// prefetch FIFO of {instr, pc}, jump redirect with in-flight discard, and halt.
module atom_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            hlt_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [XLEN-1:0] issue_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   discard_cnt;
    logic [CW-1:0]   out_next;
    logic [CW:0]     credits_used;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] data_q [FIFO_DEPTH];
    logic [XLEN-1:0] pc_q   [FIFO_DEPTH];
    logic [XLEN-1:0] jump_tgt;
    logic            grant;
    logic            rsp;
    logic            push;
    logic            pop;

    // Every request in flight already owns a FIFO slot, so a response can never overflow it.
    always_comb begin
        credits_used = {1'b0, outstanding} + {1'b0, fifo_count};
        imem_req_o   = rst_ni && !hlt_i && !jump_i && (credits_used < {1'b0, DEPTH_C});
        grant        = imem_req_o && imem_gnt_i;
        rsp          = imem_rvalid_i && (outstanding != '0);
        push         = rsp && !jump_i && (discard_cnt == '0);
        pop          = instr_valid_o && instr_ready_i && !jump_i;
        out_next     = outstanding + CW'(grant) - CW'(rsp);
        jump_tgt     = jump_addr_i & ~XLEN'(1);
    end

    assign imem_addr_o   = issue_pc;
    assign instr_valid_o = (fifo_count != '0);
    assign instr_o       = data_q[rd_ptr];
    assign instr_pc_o    = pc_q[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            fifo_count  <= '0;
            discard_cnt <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            outstanding <= out_next;
            if (jump_i) begin
                // Everything still in flight after this edge belongs to the old stream.
                issue_pc    <= jump_tgt;
                rsp_pc      <= jump_tgt;
                discard_cnt <= out_next;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fifo_count  <= '0;
            end else begin
                if (grant) begin
                    issue_pc <= issue_pc + XLEN'(4);
                end
                if (rsp && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
                if (push) begin
                    data_q[wr_ptr] <= imem_rdata_i;
                    pc_q[wr_ptr]   <= rsp_pc;
                    wr_ptr         <= wr_ptr + PW'(1);
                    rsp_pc         <= rsp_pc + XLEN'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (fifo_count == DEPTH_C)));

endmodule
